gf2m_iter_squarer: RTL and testbench

GF2M_ITER_SQUARER -- requirements
Module: gf2m_iter_squarer

---
 rtl/gf2m_iter_squarer_if.sv | 22 ++
 rtl/gf2m_iter_squarer.sv | 145 ++++++++++++++
 tb/tb_gf2m_iter_squarer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gf2m_iter_squarer_if.sv
// Request/result bundle for gf2m_iter_squarer.
//   start : request, taken only while busy=0
//   a     : operand polynomial (M bits), sampled with an accepted start
//   k     : number of squarings (KW bits), sampled with an accepted start
//   busy  : high from the accepting edge through the done cycle
//   done  : one-cycle pulse, c is valid while it is high
//   c     : registered result a^(2^k) mod f
// The master drives the request side; the slave (the squarer) drives the results.
interface gf2m_iter_squarer_if #(
    parameter int M  = 163,
    parameter int KW = 8
);
    logic          start;
    logic [M-1:0]  a;
    logic [KW-1:0] k;
    logic          busy;
    logic          done;
    logic [M-1:0]  c;

    modport master (output start, a, k, input busy, done, c);
    modport slave  (input start, a, k, output busy, done, c);
endinterface

// File: rtl/gf2m_iter_squarer.sv
// Iterated squarer in GF(2^M): c = a^(2^k) mod f, with f = x^M + F.
// Up to S squarings are applied per clock through a chain of fixed-polynomial
// squaring stages; the last step of an operation takes an intermediate tap of
// the chain so that exactly k squarings are applied.
// Ports:
//   clk   : rising-edge clock for all state
//   rst_n : asynchronous active-low reset
//   bus   : gf2m_iter_squarer_if.slave (start/a/k in, busy/done/c out)
module gf2m_iter_squarer #(
    parameter int           M  = 163,
    parameter logic [M-1:0] F  = 'hC9,
    parameter int           S  = 1,
    parameter int           KW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gf2m_iter_squarer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [M-1:0]  work_q,  work_d;
    logic [KW-1:0] rem_q,   rem_d;
    logic [M-1:0]  c_q,     c_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    // Multiply by x modulo f.
    function automatic logic [M-1:0] mul_x(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? F : '0);
    endfunction

    // Square modulo f. Spreading a[i] to bit 2i and reducing is evaluated in
    // Horner form: r <- r*x^2 + a[i], taking coefficients from the top down,
    // so the reduction stays M bits wide at every step. With F a constant this
    // folds to a pure XOR network.
    function automatic logic [M-1:0] gf_sqr(input logic [M-1:0] x);
        logic [M-1:0] r;
        logic [M-1:0] xs;
        r  = '0;
        xs = x;
        for (int i = 0; i < M; i++) begin
            r    = mul_x(mul_x(r));
            r[0] = r[0] ^ xs[M-1];
            xs   = xs << 1;
        end
        return r;
    endfunction

    // tap[j] = work_q squared j times, j = 1..S.
    logic [M-1:0] tap [1:S];

    generate
        for (genvar gi = 0; gi < S; gi++) begin : g_sq
            logic [M-1:0] sq_in;
            logic [M-1:0] sq_out;
            if (gi == 0) begin : g_first
                assign sq_in = work_q;
            end else begin : g_next
                assign sq_in = g_sq[gi-1].sq_out;
            end
            assign sq_out    = gf_sqr(sq_in);
            assign tap[gi+1] = sq_out;
        end
    endgenerate

    // A short final step (remaining < S) takes the tap equal to the remaining
    // count; otherwise the full chain output is used.
    logic [M-1:0] step_res;
    always_comb begin
        step_res = tap[S];
        for (int i = 1; i < S; i++) begin
            if (int'(rem_q) == i) begin
                step_res = tap[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        c_d     = c_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d = bus.a;
                    rem_d  = bus.k;
                    if (bus.k == '0) begin
                        state_d = DONE;
                        c_d     = bus.a;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                work_d = step_res;
                // Saturate at zero instead of subtracting S so the count
                // can never wrap on the last step.
                rem_d  = (int'(rem_q) <= S) ? '0 : rem_q - KW'(S);
                if (rem_d == '0) begin
                    state_d = DONE;
                    c_d     = step_res;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.c    = c_q;

endmodule

// File: tb/tb_gf2m_iter_squarer.sv
// Bench for gf2m_iter_squarer: four instances with S = 1..4 run side by side.
// A reference model (GF(2^M) shift-and-add multiply, latency ceil(k/S)) predicts
// busy, done and c for every instance; a negedge process compares every cycle.
module tb_gf2m_iter_squarer;
    localparam int           M  = 163;
    localparam int           KW = 8;
    localparam int           N  = 4;
    localparam logic [M-1:0] F  = 163'hC9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start_v [N];
    logic [M-1:0]  a_v     [N];
    logic [KW-1:0] k_v     [N];
    logic          busy_v  [N];
    logic          done_v  [N];
    logic [M-1:0]  c_v     [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            gf2m_iter_squarer_if #(.M(M), .KW(KW)) bus ();
            assign bus.start  = start_v[gi];
            assign bus.a      = a_v[gi];
            assign bus.k      = k_v[gi];
            assign busy_v[gi] = bus.busy;
            assign done_v[gi] = bus.done;
            assign c_v[gi]    = bus.c;
            gf2m_iter_squarer #(.M(M), .F(F), .S(gi + 1), .KW(KW)) dut (
                .clk   (clk),
                .rst_n (rst_n),
                .bus   (bus)
            );
        end
    endgenerate

    int checks   = 0;
    int failures = 0;

    // ---------------- reference arithmetic ----------------
    function automatic logic [M-1:0] m_mulx(input logic [M-1:0] v);
        return (v << 1) ^ (v[M-1] ? F : '0);
    endfunction

    function automatic logic [M-1:0] m_mul(input logic [M-1:0] x, input logic [M-1:0] y);
        logic [M-1:0] r, xx, yy;
        r = '0; xx = x; yy = y;
        for (int i = 0; i < M; i++) begin
            if (xx[0]) r = r ^ yy;
            xx = xx >> 1;
            yy = m_mulx(yy);
        end
        return r;
    endfunction

    function automatic logic [M-1:0] m_pow2k(input logic [M-1:0] x, input int kk);
        logic [M-1:0] r;
        r = x;
        for (int i = 0; i < kk; i++) r = m_mul(r, r);
        return r;
    endfunction

    function automatic logic [M-1:0] rand_vec();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[M-1:0];
    endfunction

    // ---------------- behavioural model ----------------
    // Per instance: active from the accepting edge (phase 0) until the edge
    // after phase == lat; done expected at phase == lat.
    logic         m_act   [N];
    int           m_phase [N];
    int           m_lat   [N];
    logic [M-1:0] m_res   [N];
    logic [M-1:0] m_c     [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_act[i]   <= 1'b0;
                m_phase[i] <= 0;
                m_lat[i]   <= 0;
                m_res[i]   <= '0;
                m_c[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_act[i]) begin
                    if (m_phase[i] == m_lat[i]) begin
                        m_act[i] <= 1'b0;
                    end else begin
                        m_phase[i] <= m_phase[i] + 1;
                        if (m_phase[i] + 1 == m_lat[i]) m_c[i] <= m_res[i];
                    end
                end else if (start_v[i]) begin
                    m_act[i]   <= 1'b1;
                    m_phase[i] <= 0;
                    m_lat[i]   <= (int'(k_v[i]) + i) / (i + 1);
                    m_res[i]   <= m_pow2k(a_v[i], int'(k_v[i]));
                    if (k_v[i] == '0) m_c[i] <= a_v[i];
                end
            end
        end
    end

    task automatic chk_bit(input string name, input int i, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[S=%0d] got=%b exp=%b at %0t", name, i + 1, got, exp, $time);
        end
    endtask

    task automatic chk_vec(input string name, input int i, input logic [M-1:0] got,
                           input logic [M-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[S=%0d] got=%h exp=%h at %0t", name, i + 1, got, exp, $time);
        end
    endtask

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            chk_bit("busy", i, busy_v[i], m_act[i]);
            chk_bit("done", i, done_v[i], m_act[i] && (m_phase[i] == m_lat[i]));
            chk_vec("c", i, c_v[i], m_c[i]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic s, input logic [M-1:0] av, input logic [KW-1:0] kv);
        for (int i = 0; i < N; i++) begin
            start_v[i] = s;
            a_v[i]     = av;
            k_v[i]     = kv;
        end
    endtask

    task automatic wait_idle();
        bit idle;
        for (int n = 0; n < 600; n++) begin
            idle = 1'b1;
            for (int i = 0; i < N; i++) if (m_act[i]) idle = 1'b0;
            if (idle) return;
            tick();
        end
        failures++;
        $display("FAIL wait_idle timeout at %0t", $time);
    endtask

    // One operation on all instances; a and k are scrambled while busy.
    task automatic run_all(input logic [M-1:0] av, input logic [KW-1:0] kv);
        set_all(1'b1, av, kv);
        tick();
        set_all(1'b0, ~av, ~kv);
        wait_idle();
        tick();
    endtask

    task automatic chk_all_c(input string name, input logic [M-1:0] exp);
        for (int i = 0; i < N; i++) chk_vec(name, i, c_v[i], exp);
    endtask

    logic [M-1:0] a1, a2, bit82, bit81;

    initial begin
        set_all(1'b0, '0, '0);
        a1    = rand_vec() | 163'h1;
        bit82 = '0; bit82[82] = 1'b1;
        bit81 = '0; bit81[81] = 1'b1;

        // hand-computed values pinning the model
        chk_vec("pin_x_sq", 0, m_pow2k(163'h2, 1), 163'h4);
        chk_vec("pin_x82_sq", 0, m_pow2k(bit82, 1), 163'h192);
        chk_vec("pin_frobenius", 0, m_pow2k(a1, M), a1);

        repeat (3) tick();
        for (int i = 0; i < N; i++) begin
            chk_bit("rst_busy", i, busy_v[i], 1'b0);
            chk_bit("rst_done", i, done_v[i], 1'b0);
            chk_vec("rst_c", i, c_v[i], '0);
        end
        rst_n = 1'b1;
        tick();

        run_all(163'h2, 8'd1);
        chk_all_c("c_x_k1", 163'h4);
        run_all(bit82, 8'd1);
        chk_all_c("c_x82_k1", 163'h192);
        run_all(a1, 8'd163);
        chk_all_c("c_frob", a1);

        // k = 0 with a second start held through the DONE cycle
        set_all(1'b1, 163'h1, 8'd0);
        tick();
        set_all(1'b1, 163'h5, 8'd3);
        tick();
        set_all(1'b0, 163'h5, 8'd3);
        wait_idle();
        tick();
        chk_all_c("c_k0", 163'h1);

        // re-pulsed start with different operands during RUN
        set_all(1'b1, bit81, 8'd5);
        tick();
        a2 = rand_vec();
        set_all(1'b1, a2, 8'd7);
        tick();
        tick();
        set_all(1'b0, a2, 8'd7);
        wait_idle();
        tick();
        chk_all_c("c_repulse", m_pow2k(bit81, 5));

        // maximum count
        a2 = rand_vec();
        run_all(a2, 8'd255);
        chk_all_c("c_kmax", m_pow2k(a2, 255));

        // reset in the middle of a long operation
        set_all(1'b1, 163'h2, 8'd200);
        tick();
        set_all(1'b0, 163'h2, 8'd200);
        repeat (49) tick();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk_bit("abort_busy", i, busy_v[i], 1'b0);
            chk_bit("abort_done", i, done_v[i], 1'b0);
            chk_vec("abort_c", i, c_v[i], '0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_all(163'h2, 8'd1);
        chk_all_c("c_after_rst", 163'h4);

        // randomized traffic, independent per instance
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                start_v[i] = ($urandom_range(0, 3) == 0);
                a_v[i]     = rand_vec();
                k_v[i]     = ($urandom_range(0, 7) == 0) ? KW'($urandom_range(0, 255))
                                                         : KW'($urandom_range(0, 12));
            end
            tick();
        end
        set_all(1'b0, '0, '0);
        wait_idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
